// File: rtl/scale_key_sequencer_if.sv
// Front-panel / scale-core signal bundle for scale_key_sequencer.
// The master side drives the raw keys and the weight sample; the slave side
// (the sequencer) returns the command pulses and status flags.
// Optional macro REJECT_CNT_EN adds the rej_count status bus.
interface scale_key_sequencer_if #(
    parameter int W_WIDTH = 16
);
    logic               acc_key;
    logic               clr_acc_key;
    logic               clr_key;
    logic [W_WIDTH-1:0] weight;
    logic               acc_pulse;
    logic               clr_acc_pulse;
    logic               clr_pulse;
    logic               reject;
    logic               stable;
    logic               busy;
`ifdef REJECT_CNT_EN
    logic [7:0]         rej_count;

    modport master (
        output acc_key, clr_acc_key, clr_key, weight,
        input  acc_pulse, clr_acc_pulse, clr_pulse, reject, stable, busy, rej_count
    );

    modport slave (
        input  acc_key, clr_acc_key, clr_key, weight,
        output acc_pulse, clr_acc_pulse, clr_pulse, reject, stable, busy, rej_count
    );
`else
    modport master (
        output acc_key, clr_acc_key, clr_key, weight,
        input  acc_pulse, clr_acc_pulse, clr_pulse, reject, stable, busy
    );

    modport slave (
        input  acc_key, clr_acc_key, clr_key, weight,
        output acc_pulse, clr_acc_pulse, clr_pulse, reject, stable, busy
    );
`endif
endinterface

// File: rtl/scale_key_sequencer.sv
// Front-end key sequencer for the electronic scale.
// Synchronizes and debounces three front-panel keys, latches press events as
// pending flags, tracks weight stability and issues one-cycle commands to the
// scale core with a fixed lockout window after each command or rejection.
// Optional macro REJECT_CNT_EN adds a saturating count of rejected accumulates.
module scale_key_sequencer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int STABLE_CYCLES   = 1000,
    parameter int LOCKOUT_CYCLES  = 200,
    parameter int W_WIDTH         = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    scale_key_sequencer_if.slave  bus
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int ST_W   = $clog2(STABLE_CYCLES + 1);
    localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

    // Key bit order used throughout: 0 = acc, 1 = clr_acc, 2 = clr.
    localparam int K_ACC     = 0;
    localparam int K_CLR_ACC = 1;
    localparam int K_CLR     = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        LOCKOUT
    } state_t;

    logic [2:0]         raw;
    logic [2:0]         sync1;
    logic [2:0]         sync2;
    logic [2:0]         level;
    logic [2:0]         level_d;
    logic [2:0]         rise;
    logic [DB_W-1:0]    db_cnt [3];
    logic [2:0]         pend;
    logic [2:0]         pend_clr;

    logic [W_WIDTH-1:0] w_prev;
    logic [ST_W-1:0]    stab_cnt;
    logic               stable_q;

    state_t             state;
    state_t             state_next;
    logic [LOCK_W-1:0]  lock_cnt;
    logic [LOCK_W-1:0]  lock_next;
    logic               acc_q, clr_acc_q, clr_q, reject_q, busy_q;
    logic               acc_next, clr_acc_next, clr_next, reject_next;

    assign raw  = {bus.clr_key, bus.clr_acc_key, bus.acc_key};
    assign rise = level & ~level_d;

    // Two-flop synchronizer for the asynchronous key inputs.
    // NOTE: every register in a clocked block uses <=, so all flops sample the
    // pre-edge values and the chain behaves as a true shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Per-key debounce: flip the level after DEBOUNCE_CYCLES consecutive disagreements.
    // NOTE: the counter array is reset explicitly element by element; it is
    // control state, not storage, so it must not power up undefined.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) db_cnt[k] <= '0;
            level   <= '0;
            level_d <= '0;
        end else begin
            level_d <= level;
            for (int k = 0; k < 3; k++) begin
                if (sync2[k] == level[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    level[k]  <= ~level[k];
                    db_cnt[k] <= '0;
                end else begin
                    db_cnt[k] <= db_cnt[k] + 1'b1;
                end
            end
        end
    end

    // Pending press flags: rising debounced edges set, FSM selection/supersede clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~pend_clr) | rise;
        end
    end

    // Weight stability tracker with saturating run-length counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_prev   <= '0;
            stab_cnt <= '0;
            stable_q <= 1'b0;
        end else begin
            w_prev   <= bus.weight;
            stable_q <= (stab_cnt == ST_W'(STABLE_CYCLES));
            if (bus.weight != w_prev) begin
                stab_cnt <= '0;
            end else if (stab_cnt != ST_W'(STABLE_CYCLES)) begin
                stab_cnt <= stab_cnt + 1'b1;
            end
        end
    end

    // FSM state, lockout counter and registered command outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lock_cnt  <= '0;
            acc_q     <= 1'b0;
            clr_acc_q <= 1'b0;
            clr_q     <= 1'b0;
            reject_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_next;
            lock_cnt  <= lock_next;
            acc_q     <= acc_next;
            clr_acc_q <= clr_acc_next;
            clr_q     <= clr_next;
            reject_q  <= reject_next;
            busy_q    <= (state_next != IDLE);
        end
    end

    // Next-state logic: priority select in IDLE, supersede in ISSUE, timed LOCKOUT.
    // NOTE: every output of this block gets a default first so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_next   = state;
        lock_next    = lock_cnt;
        pend_clr     = '0;
        acc_next     = 1'b0;
        clr_acc_next = 1'b0;
        clr_next     = 1'b0;
        reject_next  = 1'b0;
        case (state)
            IDLE: begin
                if (pend[K_CLR]) begin
                    pend_clr[K_CLR] = 1'b1;
                    clr_next        = 1'b1;
                    state_next      = ISSUE;
                end else if (pend[K_CLR_ACC]) begin
                    pend_clr[K_CLR_ACC] = 1'b1;
                    clr_acc_next        = 1'b1;
                    state_next          = ISSUE;
                end else if (pend[K_ACC]) begin
                    pend_clr[K_ACC] = 1'b1;
                    if (stable_q && (bus.weight != '0)) begin
                        acc_next   = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        reject_next = 1'b1;
                        lock_next   = '0;
                        state_next  = LOCKOUT;
                    end
                end
            end
            ISSUE: begin
                // A clear makes any queued accumulate or clear-accumulate moot.
                if (clr_q) begin
                    pend_clr[K_CLR_ACC] = 1'b1;
                    pend_clr[K_ACC]     = 1'b1;
                end else if (clr_acc_q) begin
                    pend_clr[K_ACC] = 1'b1;
                end
                lock_next  = '0;
                state_next = LOCKOUT;
            end
            LOCKOUT: begin
                if (lock_cnt == LOCK_W'(LOCKOUT_CYCLES - 1)) begin
                    state_next = IDLE;
                end else begin
                    lock_next = lock_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.acc_pulse     = acc_q;
    assign bus.clr_acc_pulse = clr_acc_q;
    assign bus.clr_pulse     = clr_q;
    assign bus.reject        = reject_q;
    assign bus.stable        = stable_q;
    assign bus.busy          = busy_q;

`ifdef REJECT_CNT_EN
    logic [7:0] rej_cnt;

    // Saturating reject counter, updated alongside the pulse it counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rej_cnt <= '0;
        end else if (clr_next) begin
            rej_cnt <= '0;
        end else if (reject_next && (rej_cnt != 8'hFF)) begin
            rej_cnt <= rej_cnt + 1'b1;
        end
    end

    assign bus.rej_count = rej_cnt;
`endif
endmodule
